// File: rtl/router_pkt_ctrl.sv
// Router ingress packet controller: steers header/payload/parity bytes to one of three FIFOs, checks parity.
// Latency: payload/parity pass through to dout combinationally; header replayed one cycle after decode.
// Backpressure: busy throttles the source (wait for empty FIFO, FIFO full, header/check cycles); stats via ROUTER_PKT_STATS_EN.
module router_pkt_ctrl #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pkt_valid,
   input  logic [DATA_W-1:0] data_in,
   input  logic [2:0]        fifo_full,
   input  logic [2:0]        fifo_empty,
   input  logic [2:0]        soft_reset,
   output logic              busy,
   output logic [2:0]        write_enb,
   output logic              lfd_state,
   output logic [DATA_W-1:0] dout,
   output logic              parity_done,
   output logic              err,
   output logic [CNT_W-1:0]  pkt_cnt,
   output logic [CNT_W-1:0]  err_cnt
);

   localparam int REM_W = DATA_W - 1;

   typedef struct packed {
      logic [DATA_W-3:0] len;
      logic [1:0]        addr;
   } hdr_t;

   typedef enum logic [2:0] {
      DECODE, WAIT, LFD, LOAD_DATA, LOAD_PARITY, CHECK, DROP
   } state_t;

   state_t            state_q, state_d;
   hdr_t              hold_q, hold_d, hdr_in;
   logic [DATA_W-1:0] par_q, par_d, chk_q, chk_d;
   logic [REM_W-1:0]  rem_q, rem_d, drop_rem;
   logic              err_q, err_d;
   logic              accept, wr, lfd, pd;
   logic [3:0]        full4, empty4, sr4;
   logic              full_sel, empty_sel, sr_sel;

   assign hdr_in    = hdr_t'(data_in);
   assign full4     = {1'b0, fifo_full};
   assign empty4    = {1'b0, fifo_empty};
   assign sr4       = {1'b0, soft_reset};
   assign full_sel  = full4[hold_q.addr];
   assign empty_sel = empty4[hold_q.addr];
   assign sr_sel    = sr4[hold_q.addr];

   always_comb begin
      busy = 1'b1;
      case (state_q)
         DECODE:                 busy = 1'b0;
         LOAD_DATA, LOAD_PARITY: busy = full_sel;
         // rem==0 only after a soft reset that swallowed the parity byte: finish without taking a byte
         DROP:                   busy = (rem_q == '0);
         default:                busy = 1'b1;
      endcase
   end

   assign accept   = pkt_valid & ~busy;
   // bytes still owed by the source, parity included, once this cycle's byte is counted
   assign drop_rem = rem_q + REM_W'(1) - REM_W'(accept);

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      par_d   = par_q;
      chk_d   = chk_q;
      rem_d   = rem_q;
      err_d   = err_q;
      wr      = 1'b0;
      lfd     = 1'b0;
      pd      = 1'b0;
      dout    = '0;
      case (state_q)
         DECODE: begin
            if (accept) begin
               hold_d = hdr_in;
               par_d  = data_in;
               rem_d  = {1'b0, hdr_in.len};
               err_d  = 1'b0;
               if (hdr_in.addr == 2'd3) begin
                  rem_d   = {1'b0, hdr_in.len} + REM_W'(1);
                  state_d = DROP;
               end else if (empty4[hdr_in.addr]) begin
                  state_d = LFD;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (sr_sel) begin
               rem_d   = drop_rem;
               state_d = DROP;
            end else if (empty_sel) begin
               state_d = LFD;
            end
         end
         LFD: begin
            dout = hold_q;
            if (sr_sel) begin
               rem_d   = drop_rem;
               state_d = DROP;
            end else begin
               wr      = 1'b1;
               lfd     = 1'b1;
               state_d = (hold_q.len != '0) ? LOAD_DATA : LOAD_PARITY;
            end
         end
         LOAD_DATA: begin
            dout = data_in;
            if (sr_sel) begin
               rem_d   = drop_rem;
               state_d = DROP;
            end else if (accept) begin
               wr    = 1'b1;
               par_d = par_q ^ data_in;
               rem_d = rem_q - REM_W'(1);
               if (rem_q == REM_W'(1)) state_d = LOAD_PARITY;
            end
         end
         LOAD_PARITY: begin
            dout = data_in;
            if (sr_sel) begin
               rem_d   = drop_rem;
               state_d = DROP;
            end else if (accept) begin
               wr      = 1'b1;
               chk_d   = data_in;
               state_d = CHECK;
            end
         end
         CHECK: begin
            pd      = 1'b1;
            err_d   = (chk_q != par_q);
            state_d = DECODE;
         end
         DROP: begin
            if (rem_q == '0) begin
               pd      = 1'b1;
               err_d   = 1'b1;
               state_d = DECODE;
            end else if (accept) begin
               rem_d = rem_q - REM_W'(1);
               if (rem_q == REM_W'(1)) begin
                  pd      = 1'b1;
                  err_d   = 1'b1;
                  state_d = DECODE;
               end
            end
         end
         default: state_d = DECODE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= DECODE;
         hold_q  <= '0;
         par_q   <= '0;
         chk_q   <= '0;
         rem_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         par_q   <= par_d;
         chk_q   <= chk_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
      end
   end

   // reset aborts the packet in the same cycle, so strobes are masked while it is asserted
   assign write_enb   = (wr & ~reset) ? (3'b001 << hold_q.addr) : 3'b000;
   assign lfd_state   = lfd & ~reset;
   assign parity_done = pd & ~reset;
   assign err         = err_q;

`ifdef ROUTER_PKT_STATS_EN
   logic [CNT_W-1:0] pkt_q, errc_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_q  <= '0;
         errc_q <= '0;
      end else if (pd) begin
         if (~&pkt_q) pkt_q <= pkt_q + CNT_W'(1);
         if (err_d && ~&errc_q) errc_q <= errc_q + CNT_W'(1);
      end
   end

   assign pkt_cnt = pkt_q;
   assign err_cnt = errc_q;
`else
   assign pkt_cnt = '0;
   assign err_cnt = '0;
`endif

endmodule
